seg7_scan: RTL
==============

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter LZ_SUPPRESS, default 0; when 1, leading zero digits are blanked.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port tick_in, input, 1, slow scan clock level from the upstream 2N divider, asynchronous to clk.
REQ-005 The block SHALL have port value, input, 16, four hex nibbles; digit d = value[4d+3:4d].
REQ-006 The block SHALL have port dp_in, input, 4, decimal-point request per digit, active-high.
REQ-007 The block SHALL have port blank, input, 4, force-blank per digit, active-high.
REQ-008 The block SHALL have port an, output, 4, digit enables, active-low, one-hot.
REQ-009 The block SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port dp, output, 1, decimal point, active-low.
REQ-011 The block SHALL have port frame_start, output, 1, one-clk pulse when scan returns to digit 0.

Function
REQ-012 tick_in SHALL pass through a two-flop synchronizer; a third flop holds the previous synchronized value.
REQ-013 step SHALL be high for exactly one clk per tick_in rising edge: synced high and previous low.
REQ-014 Digit index idx (2 bits) SHALL advance on the clk edge where step=1, i.e. the 3rd rising clk edge after tick_in rises (setup met); sequence 0,1,2,3,0; 3->0 wraps.
REQ-015 Falling edges of tick_in SHALL NOT advance idx; a tick_in pulse shorter than 2 clk periods MAY be missed.
REQ-016 A snapshot register {value, dp_in, blank} SHALL load on the same edge idx wraps 3->0; all digits of one frame display one snapshot (no tearing).
REQ-017 Input changes between wraps SHALL NOT affect displayed data until the next wrap.
REQ-018 an, seg, dp SHALL be registered and SHALL reflect the current idx and snapshot one clk after idx changes.
REQ-019 an SHALL be ~(4'b0001 << idx) unless the digit is blanked, in which case an=4'b1111.
REQ-020 seg SHALL decode the snapshot nibble as hex, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 dp SHALL be ~snapshot dp_in[idx] when not blanked, else 1.
REQ-022 A digit SHALL be blanked if snapshot blank[idx]=1, or LZ_SUPPRESS=1 and all nibbles from digit 3 down to idx are zero and idx!=0; digit 0 is never zero-suppressed.
REQ-023 Blanked digit SHALL output seg=1111111, dp=1, an=1111.
REQ-024 frame_start SHALL pulse high for one clk, aligned with the output update for idx=0 after a 3->0 wrap.

Reset
REQ-025 On a clk edge with reset=1: idx=0, synchronizer and previous flops=0, snapshot=0, an=1111, seg=1111111, dp=1, frame_start=0.
REQ-026 Reset SHALL override a coincident step; reset mid-frame SHALL return to idx 0 without a frame_start pulse.
REQ-027 If tick_in is high across reset release, one step SHALL occur on the 3rd edge after release (defined behaviour, not an error).
REQ-028 The first frame after reset SHALL display the zero snapshot until the first 3->0 wrap.

Verification
REQ-029 value=16'h12AF, dp_in=0, blank=0, 8 tick_in rising edges -> after the first wrap, scan an=1110/1101/1011/0111 with seg F,A,2,1 codes, frame_start once per 4 steps.
REQ-030 tick_in rising -> idx advances on 3rd clk edge; an/seg change one clk later; tick_in falling -> no change.
REQ-031 value changed mid-frame from 16'h0000 to 16'h8888 -> remaining digits of current frame still show 0; next frame shows 8 (0000000).
REQ-032 LZ_SUPPRESS=1, value=16'h0040 -> digits 3,2 blanked (an=1111), digit 1 shows 4, digit 0 shows 0; value=16'h0000 -> only digit 0 lit.
REQ-033 blank=4'b0100, dp_in=4'b0001 -> digit 2 dark; digit 0 dp=0; others dp=1.
REQ-034 reset asserted at idx=2 -> next edge an=1111, seg=1111111, idx=0, no frame_start; scan resumes from digit 0 on next tick.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner: synchronizes the external scan tick,
// steps the digit index, and drives registered active-low anode/segment/dp outputs.
module seg7_scan #(
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [1:0]  r_idx;
  logic [15:0] r_val;
  logic [3:0]  r_dp;
  logic [3:0]  r_blank;
  logic        r_wrap;

  logic        w_step;
  logic        w_wrap;
  logic [3:0]  w_nib;
  logic        w_upper_zero;
  logic        w_blanked;
  logic [6:0]  w_seg;

  assign w_step = r_sync2 & ~r_prev;
  assign w_wrap = w_step & (r_idx == 2'd3);

  // Digit 0 is never zero-suppressed, so its leading-zero term stays low.
  always_comb begin
    w_nib        = r_val[3:0];
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib        = r_val[3:0];
        w_upper_zero = 1'b0;
      end
      2'd1: begin
        w_nib        = r_val[7:4];
        w_upper_zero = (r_val[15:4] == 12'd0);
      end
      2'd2: begin
        w_nib        = r_val[11:8];
        w_upper_zero = (r_val[15:8] == 8'd0);
      end
      default: begin
        w_nib        = r_val[15:12];
        w_upper_zero = (r_val[15:12] == 4'd0);
      end
    endcase
  end

  assign w_blanked = r_blank[r_idx] | (LZ_SUPPRESS & w_upper_zero);

  always_comb begin
    w_seg = '1;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      default: w_seg = 7'b0001110;
    endcase
  end

  // Outputs are computed from the pre-edge index/snapshot, so they trail idx by one clk;
  // r_wrap delays the wrap marker by the same amount to align frame_start with digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_idx       <= '0;
      r_val       <= '0;
      r_dp        <= '0;
      r_blank     <= '0;
      r_wrap      <= 1'b0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_sync1 <= tick_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_wrap  <= w_wrap;
      if (w_step) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_wrap) begin
        r_val   <= value;
        r_dp    <= dp_in;
        r_blank <= blank;
      end
      an          <= w_blanked ? 4'b1111 : ~(4'b0001 << r_idx);
      seg         <= w_blanked ? 7'b1111111 : w_seg;
      dp          <= w_blanked | ~r_dp[r_idx];
      frame_start <= r_wrap;
    end
  end

endmodule
